bcd_field_counter: RTL and testbench
====================================

// Module: bcd_field_counter
// PURPOSE
//  Parametrised BCD calendar/clock field counter (sec, min, hour, day, month, year).
//  Wraps from MAX to MIN, supports parallel load, and gates its value onto a shared databus.
//  Produces a same-cycle carry so fields cascade into a full clock/calendar chain.
//  The DYN_MAX port bounds the day-of-month field from the month/year logic.
// PARAMETERS
//  DIGITS   2      number of BCD digits; W = 4*DIGITS
//  MIN      'h00   wrap-to value, BCD encoded (e.g. 'h01 for day/month)
//  MAX      'h59   static terminal value, BCD encoded
//  DYN_MAX  0      1 = terminal value taken from max_in; 0 = use MAX
// PORTS
//  clk       in   1  system clock, all state on rising edge
//  clear     in   1  synchronous reset, active-high
//  tick      in   1  advance strobe (1 step per cycle while high)
//  load      in   1  parallel load strobe
//  data      in   W  BCD load value
//  max_in    in   W  dynamic terminal value (BCD); ignored when DYN_MAX=0
//  enable    in   1  databus output enable
//  value     out  W  current count (registered, BCD)
//  databus   out  W  value when enable=1, else all zeros
//  carry     out  1  combinational wrap indication for the next field's tick
//  load_err  out  1  registered one-cycle pulse: rejected load
// BEHAVIOUR
//  - Reset (clear=1 at edge): value<=MIN, load_err<=0. Overrides load/tick.
//  - Priority at each edge: clear > load > tick > hold.
//  - max_eff = DYN_MAX ? max_in : MAX.
//  - tick, value >= max_eff: value<=MIN (covers max_in shrinking below value, e.g. day 31 -> Feb).
//  - tick, value <  max_eff: value<=value+1 in BCD; digit 9 -> 0 with carry into next digit.
//  - carry = tick & ~load & ~clear & (value >= max_eff). Same cycle, 0-latency, so the
//    next field steps on the same edge. Comparisons are on the BCD code.
//  - load: if data has any digit > 9, or data < MIN, or data > max_eff: value holds
//    and load_err<=1 for one cycle. Otherwise value<=data, load_err<=0.
//  - load_err is 0 on every edge without a rejected load.
//  - load with tick in the same cycle: load wins, no increment, carry=0.
//  - databus = {W{enable}} & value. Purely combinational, no latency.
//  - Latency: value changes one edge after tick/load. Carry has no register stage.
// CONFIGURATION
//  - Macro BCD_FIELD_DOWN_EN:
//    - Defined: adds input port 'down' (1 bit, after tick).
//    - down=1 & tick: value <= MIN -> max_eff, else BCD decrement (digit 0 -> 9 with borrow).
//    - Carry (borrow) = tick & ~load & ~clear & (value <= MIN).
//    - down=0: identical to the undefined build.
//  - Not defined: no down port; up-count only as above.
// STRUCTURE
//  - Shared package cal_pkg:
//    - BCD_W=4 and bcd_digit_t typedef.
//    - Field limit constants: SEC_MAX 'h59, HOUR_MAX 'h23, MONTH_MAX 'h12, DAY_MIN 'h01.
//    - Function bcd_valid(W-bit) returning 1 when all digits <= 9.
//  - One sub-module, bcd_digit_step: 4-bit digit, ci/dir in; next digit, co out.
//    Instantiated DIGITS times as a ripple chain.
// TESTING
//  1. clear=1 from value 'h37 -> next edge value='h00, load_err=0, carry=0.
//  2. MAX='h59, value 'h58, tick 2 cycles -> 'h59 (carry=0), then 'h00 with carry=1 in the 'h59 cycle.
//  3. DYN_MAX=1, MIN='h01, value 'h31, max_in='h28, tick -> value 'h01, carry=1.
//  4. load data='h4A -> value unchanged, load_err=1 one cycle.
//     load data='h45 with tick=1 -> value 'h45, carry=0.
//  5. enable=0 -> databus='h00; enable=1 -> databus=value in the same cycle.
//  6. BCD_FIELD_DOWN_EN, MIN='h01, MAX='h12, value 'h01, down=1, tick -> value 'h12, carry=1;
//     value 'h10 -> 'h09.

Source files
------------

// File: rtl/cal_pkg.sv
// Shared definitions for the BCD calendar/clock field counters.
// Contents:
//   BCD_W, BCD_MAX_W  digit width and widest supported field (8 digits)
//   bcd_digit_t       one BCD digit
//   SEC_MAX, HOUR_MAX, MONTH_MAX, DAY_MIN  common field limits
//   bcd_valid()       1 when every digit of a (zero-extended) field is <= 9
package cal_pkg;

  localparam int BCD_W     = 4;
  localparam int BCD_MAX_W = 32;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  localparam logic [7:0] SEC_MAX   = 8'h59;
  localparam logic [7:0] HOUR_MAX  = 8'h23;
  localparam logic [7:0] MONTH_MAX = 8'h12;
  localparam logic [7:0] DAY_MIN   = 8'h01;

  // Narrower fields are zero-extended; leading zero digits are always valid.
  function automatic logic bcd_valid(input logic [BCD_MAX_W-1:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < BCD_MAX_W / BCD_W; i++) begin
      if (v[i*BCD_W +: BCD_W] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the ripple increment/decrement chain.
// Ports:
//   digit in  4  current digit
//   ci    in  1  step request from the lower digit (1 for the lowest digit)
//   dir   in  1  0 = count up, 1 = count down
//   nxt   out 4  stepped digit
//   co    out 1  carry (up, 9 -> 0) or borrow (down, 0 -> 9) into the next digit
module bcd_digit_step
  import cal_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       ci,
  input  logic       dir,
  output bcd_digit_t nxt,
  output logic       co
);

  // Digit step with wrap at the BCD boundaries.
  always_comb begin
    nxt = digit;
    co  = 1'b0;
    if (ci) begin
      if (dir) begin
        if (digit == 4'd0) begin
          nxt = 4'd9;
          co  = 1'b1;
        end else begin
          nxt = digit - 4'd1;
          co  = 1'b0;
        end
      end else begin
        // >= also folds illegal codes back to 0 rather than counting into A-F
        if (digit >= 4'd9) begin
          nxt = 4'd0;
          co  = 1'b1;
        end else begin
          nxt = digit + 4'd1;
          co  = 1'b0;
        end
      end
    end else begin
      nxt = digit;
      co  = 1'b0;
    end
  end

endmodule

// File: rtl/bcd_field_counter.sv
// BCD calendar/clock field counter (sec/min/hour/day/month/year).
// Wraps MAX -> MIN, parallel load with validation, databus gating and a
// same-cycle carry for cascading into the next field.
// Optional build macro BCD_FIELD_DOWN_EN adds the 'down' port (count down,
// MIN -> max_eff wrap with borrow on carry).
// Ports:
//   clk      in  1  clock, rising edge
//   clear    in  1  synchronous reset, active-high
//   tick     in  1  advance strobe
//   down     in  1  (BCD_FIELD_DOWN_EN only) count direction, 1 = down
//   load     in  1  parallel load strobe
//   data     in  W  BCD load value
//   max_in   in  W  dynamic terminal value, used when DYN_MAX=1
//   enable   in  1  databus output enable
//   value    out W  current count (registered)
//   databus  out W  value when enable=1, else zero
//   carry    out 1  combinational wrap indication
//   load_err out 1  registered pulse for a rejected load
module bcd_field_counter
  import cal_pkg::*;
#(
  parameter int                  DIGITS  = 2,
  parameter logic [4*DIGITS-1:0] MIN     = 8'h00,
  parameter logic [4*DIGITS-1:0] MAX     = 8'h59,
  parameter int                  DYN_MAX = 0
) (
  input  logic                clk,
  input  logic                clear,
  input  logic                tick,
`ifdef BCD_FIELD_DOWN_EN
  input  logic                down,
`endif
  input  logic                load,
  input  logic [4*DIGITS-1:0] data,
  input  logic [4*DIGITS-1:0] max_in,
  input  logic                enable,
  output logic [4*DIGITS-1:0] value,
  output logic [4*DIGITS-1:0] databus,
  output logic                carry,
  output logic                load_err
);

  localparam int W = 4 * DIGITS;

  logic [W-1:0]    min_s;
  logic [W-1:0]    max_eff_s;
  logic [W-1:0]    ripple_s;
  logic [DIGITS:0] chain_s;
  logic            dir_s;
  logic            at_term_s;
  logic [W-1:0]    step_s;
  logic            load_ok_s;

  assign min_s     = MIN;
  assign max_eff_s = (DYN_MAX != 0) ? max_in : MAX;

`ifdef BCD_FIELD_DOWN_EN
  assign dir_s = down;
`else
  assign dir_s = 1'b0;
`endif

  assign chain_s[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_step u_step (
        .digit (value[g*BCD_W +: BCD_W]),
        .ci    (chain_s[g]),
        .dir   (dir_s),
        .nxt   (ripple_s[g*BCD_W +: BCD_W]),
        .co    (chain_s[g+1])
      );
    end
  endgenerate

  // Terminal detection and the value a tick would produce.
  // Using >= / <= (not ==) also wraps a value left outside a shrunken
  // max_in, e.g. day 31 when the month changes to February. An all-nines
  // field cannot step further up, so a ripple carry-out also wraps.
  always_comb begin
    if (dir_s) begin
      at_term_s = (value <= min_s);
      step_s    = at_term_s ? max_eff_s : ripple_s;
    end else begin
      at_term_s = (value >= max_eff_s) | chain_s[DIGITS];
      step_s    = at_term_s ? min_s : ripple_s;
    end
  end

  assign load_ok_s = bcd_valid(32'(data)) && (data >= min_s) && (data <= max_eff_s);

  assign carry   = tick & ~load & ~clear & at_term_s;
  assign databus = {W{enable}} & value;

  // Field register: clear > load > tick > hold.
  always_ff @(posedge clk) begin
    if (clear) begin
      value    <= MIN;
      load_err <= 1'b0;
    end else if (load) begin
      if (load_ok_s) begin
        value    <= data;
        load_err <= 1'b0;
      end else begin
        value    <= value;
        load_err <= 1'b1;
      end
    end else if (tick) begin
      value    <= step_s;
      load_err <= 1'b0;
    end else begin
      value    <= value;
      load_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bcd_field_counter.sv
// Self-checking bench: two counters (static 00..59, dynamic 01..max_in)
// driven with directed then random stimulus, compared against a decimal
// reference model.
module tb_bcd_field_counter;

  logic       clk = 1'b0;
  logic       clear, tick, load, enable, dn;
  logic [7:0] data, max_in;
  logic [7:0] value_a, databus_a, value_b, databus_b;
  logic       carry_a, load_err_a, carry_b, load_err_b;

  int n_checks = 0;
  int n_pass   = 0;
  int ma, mb;          // model values, decimal
  bit ea, eb;          // model load_err

  always #5 clk = ~clk;

  bcd_field_counter #(.DIGITS(2), .MIN(8'h00), .MAX(8'h59), .DYN_MAX(0)) u_a (
    .clk(clk), .clear(clear), .tick(tick),
`ifdef BCD_FIELD_DOWN_EN
    .down(dn),
`endif
    .load(load), .data(data), .max_in(max_in), .enable(enable),
    .value(value_a), .databus(databus_a), .carry(carry_a), .load_err(load_err_a)
  );

  bcd_field_counter #(.DIGITS(2), .MIN(8'h01), .MAX(8'h31), .DYN_MAX(1)) u_b (
    .clk(clk), .clear(clear), .tick(tick),
`ifdef BCD_FIELD_DOWN_EN
    .down(dn),
`endif
    .load(load), .data(data), .max_in(max_in), .enable(enable),
    .value(value_b), .databus(databus_b), .carry(carry_b), .load_err(load_err_b)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int bcd2i(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] i2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  function automatic bit ok_load(input logic [7:0] d, input int mn, input int mx);
    if (d[7:4] > 4'd9 || d[3:0] > 4'd9) return 1'b0;
    return (bcd2i(d) >= mn) && (bcd2i(d) <= mx);
  endfunction

  function automatic bit exp_carry(input int v, input int mn, input int mx);
    if (!tick || load || clear) return 1'b0;
    return dn ? (v <= mn) : (v >= mx);
  endfunction

  task automatic model_step(inout int v, output bit err, input int mn, input int mx);
    err = 1'b0;
    if (clear) v = mn;
    else if (load) begin
      if (ok_load(data, mn, mx)) v = bcd2i(data);
      else err = 1'b1;
    end else if (tick) begin
      if (dn) v = (v <= mn) ? mx : v - 1;
      else    v = (v >= mx) ? mn : v + 1;
    end
  endtask

  // One clock: drive on negedge, check combinational outputs, step, check registers.
  task automatic cycle(input bit c, input bit t, input bit l, input bit d_n,
                       input logic [7:0] d, input logic [7:0] mx, input bit en);
    int mxb;
    @(negedge clk);
    clear = c; tick = t; load = l; dn = d_n; data = d; max_in = mx; enable = en;
    #1;
    mxb = bcd2i(mx);
    check_eq("carry_a", {31'd0, carry_a}, {31'd0, exp_carry(ma, 0, 59)});
    check_eq("carry_b", {31'd0, carry_b}, {31'd0, exp_carry(mb, 1, mxb)});
    check_eq("bus_a", {24'd0, databus_a}, en ? {24'd0, i2bcd(ma)} : 32'd0);
    check_eq("bus_b", {24'd0, databus_b}, en ? {24'd0, i2bcd(mb)} : 32'd0);
    @(posedge clk);
    model_step(ma, ea, 0, 59);
    model_step(mb, eb, 1, mxb);
    #1;
    check_eq("value_a", {24'd0, value_a}, {24'd0, i2bcd(ma)});
    check_eq("value_b", {24'd0, value_b}, {24'd0, i2bcd(mb)});
    check_eq("err_a", {31'd0, load_err_a}, {31'd0, ea});
    check_eq("err_b", {31'd0, load_err_b}, {31'd0, eb});
  endtask

  initial begin
    logic [7:0] d, mx;
    bit c, t, l, dd, en;
    clear = 1'b1; tick = 1'b0; load = 1'b0; dn = 1'b0; data = 8'h00;
    max_in = 8'h31; enable = 1'b1;
    ma = 0; mb = 1;
    repeat (2) @(posedge clk);

    // reset from 'h37, with load and tick also asserted
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h37, 8'h31, 1'b1);
    check_eq("load37", {24'd0, value_a}, 32'h37);
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h12, 8'h31, 1'b1);
    check_eq("clr_val", {24'd0, value_a}, 32'h00);
    check_eq("clr_err", {31'd0, load_err_a}, 32'd0);

    // 58 -> 59 -> 00 with carry in the 59 cycle
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h58, 8'h31, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h31, 1'b1);
    check_eq("to59", {24'd0, value_a}, 32'h59);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h31, 1'b1);
    check_eq("wrap00", {24'd0, value_a}, 32'h00);

    // day 31 with max_in shrinking to 28
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h31, 8'h31, 1'b1);
    @(negedge clk);
    tick = 1'b1; load = 1'b0; max_in = 8'h28;
    #1 check_eq("feb_carry", {31'd0, carry_b}, 32'd1);
    @(posedge clk);
    model_step(ma, ea, 0, 59);
    model_step(mb, eb, 1, 28);
    #1 check_eq("feb_wrap", {24'd0, value_b}, 32'h01);

    // invalid digit rejected, then load beats tick
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h4A, 8'h31, 1'b1);
    check_eq("rej_err", {31'd0, load_err_a}, 32'd1);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'h45, 8'h31, 1'b1);
    check_eq("ld45", {24'd0, value_a}, 32'h45);
    check_eq("err_pulse", {31'd0, load_err_a}, 32'd0);

    // databus gating
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h31, 1'b0);
    check_eq("bus_off", {24'd0, databus_a}, 32'h00);

`ifdef BCD_FIELD_DOWN_EN
    // down: 01 -> max, 10 -> 09
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 8'h12, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h12, 1'b1);
    check_eq("dn_wrap", {24'd0, value_b}, 32'h12);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 8'h12, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h12, 1'b1);
    check_eq("dn_borrow", {24'd0, value_b}, 32'h09);
`endif

    for (int i = 0; i < 600; i++) begin
      c  = ($urandom_range(0, 39) == 0);
      t  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 5) == 0);
`ifdef BCD_FIELD_DOWN_EN
      dd = ($urandom_range(0, 2) == 0);
`else
      dd = 1'b0;
`endif
      en = ($urandom_range(0, 3) != 0);
      d  = ($urandom_range(0, 2) == 0) ? 8'($urandom) : i2bcd($urandom_range(0, 65));
      mx = ($urandom_range(0, 4) == 0) ? i2bcd($urandom_range(1, 31))
                                       : i2bcd($urandom_range(28, 31));
      cycle(c, t, l, dd, d, mx, en);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
